// File: rtl/dmu_responder.sv
// Data-memory responder: captures one load/store, waits LATENCY cycles, then
// commits the store or returns load data with a one-cycle done pulse.
module dmu_responder #(
  parameter int WIDTH       = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             read_en,
  input  logic             write_en,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] Mem_addr_out,
  input  logic [WIDTH-1:0] RS2_data_out,
  output logic [WIDTH-1:0] dmu_out_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       f3_q, f3_d;
  logic [AW+1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             rd_q, rd_d;
  logic             wr_q, wr_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             err_q, err_d;

  logic [WIDTH-1:0] mem [DEPTH_WORDS];
  logic [AW-1:0]    idx;
  logic [WIDTH-1:0] rd_word;
  logic [WIDTH-1:0] rd_shift;
  logic [7:0]       byte_v;
  logic [15:0]      half_v;
  logic [WIDTH-1:0] load_v;
  logic [WIDTH-1:0] wmask;
  logic [WIDTH-1:0] wdata_sh;
  logic             bad_f3;
  logic             misalign;
  logic             bad;
  logic             mem_we;
  logic             unused_addr_bits;

  // Upper address bits only alias; they never reach the array.
  assign unused_addr_bits = ^Mem_addr_out[WIDTH-1:AW+2];

  assign idx      = addr_q[AW+1:2];
  assign rd_word  = mem[idx];
  assign rd_shift = rd_word >> {addr_q[1:0], 3'b000};
  assign byte_v   = rd_shift[7:0];
  assign half_v   = rd_shift[15:0];
  assign wdata_sh = wdata_q << {addr_q[1:0], 3'b000};

  always_comb begin
    bad_f3 = 1'b0;
    if (rd_q && !wr_q) begin
      unique case (f3_q)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: bad_f3 = 1'b0;
        default:                                bad_f3 = 1'b1;
      endcase
    end else if (wr_q && !rd_q) begin
      unique case (f3_q)
        3'b000, 3'b001, 3'b010: bad_f3 = 1'b0;
        default:                bad_f3 = 1'b1;
      endcase
    end
    misalign = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
               ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    bad      = (rd_q && wr_q) || bad_f3 || misalign;
  end

  always_comb begin
    load_v = '0;
    wmask  = '0;
    unique case (f3_q)
      3'b000: begin
        load_v = {{(WIDTH-8){byte_v[7]}}, byte_v};
        wmask  = {{(WIDTH-8){1'b0}}, 8'hFF} << {addr_q[1:0], 3'b000};
      end
      3'b001: begin
        load_v = {{(WIDTH-16){half_v[15]}}, half_v};
        wmask  = {{(WIDTH-16){1'b0}}, 16'hFFFF} << {addr_q[1:0], 3'b000};
      end
      3'b010: begin
        load_v = rd_word;
        wmask  = '1;
      end
      3'b100: load_v = {{(WIDTH-8){1'b0}}, byte_v};
      3'b101: load_v = {{(WIDTH-16){1'b0}}, half_v};
      default: begin
        load_v = '0;
        wmask  = '0;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    out_d   = out_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (read_en || write_en) begin
          f3_d    = Funct3;
          addr_d  = Mem_addr_out[AW+1:0];
          wdata_d = RS2_data_out;
          rd_d    = read_en;
          wr_d    = write_en;
          cnt_d   = CW'(LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          err_d   = bad;
          out_d   = (bad || !rd_q) ? '0 : load_v;
          mem_we  = wr_q && !bad;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately outside reset; a reset forces IDLE, so mem_we drops.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= (rd_word & ~wmask) | (wdata_sh & wmask);
  end

  assign dmu_out_data = out_q;
  assign err          = err_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == RESP);

endmodule

// File: tb/tb_dmu_responder.sv
// Directed bench for dmu_responder with hand-computed expected values.
module tb_dmu_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        read_en, write_en;
  logic [2:0]  Funct3;
  logic [31:0] Mem_addr_out, RS2_data_out;
  logic [31:0] dmu_out_data;
  logic        busy, done, err;

  int checks   = 0;
  int failures = 0;

  logic [31:0] rdata;
  logic        rerr;
  int          cyc;
  int          ndone;

  dmu_responder #(.WIDTH(32), .DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .read_en(read_en), .write_en(write_en),
    .Funct3(Funct3), .Mem_addr_out(Mem_addr_out), .RS2_data_out(RS2_data_out),
    .dmu_out_data(dmu_out_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for done (bounded), return data/err/latency.
  task automatic req(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] addr, input logic [31:0] wd,
                     output logic [31:0] data, output logic e, output int n);
    read_en = rd; write_en = wr; Funct3 = f3; Mem_addr_out = addr; RS2_data_out = wd;
    @(posedge clk); #1;
    read_en = 1'b0; write_en = 1'b0; Mem_addr_out = 32'hFFFF_FFFF; RS2_data_out = 32'h0;
    n = 0;
    while (!done && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) chk("timeout", 32'(n), 32'd3);
    data = dmu_out_data;
    e    = err;
    @(posedge clk); #1;
    chk("done_single", {31'b0, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; read_en = 1'b0; write_en = 1'b0; Funct3 = 3'b0;
    Mem_addr_out = '0; RS2_data_out = '0;
    #12;
    chk("rst_data", dmu_out_data, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_err",  {31'b0, err},  32'd0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // Word round trip
    req(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, rdata, rerr, cyc);
    chk("sw_data", rdata, 32'd0);
    chk("sw_err", {31'b0, rerr}, 32'd0);
    chk("sw_lat", 32'(cyc), 32'd3);
    req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rdata, rerr, cyc);
    chk("lw_data", rdata, 32'hDEAD_BEEF);
    chk("lw_err", {31'b0, rerr}, 32'd0);
    chk("lw_lat", 32'(cyc), 32'd3);

    // Byte and halfword lanes
    req(1'b0, 1'b1, 3'b010, 32'h20, 32'h1122_3344, rdata, rerr, cyc);
    req(1'b0, 1'b1, 3'b000, 32'h21, 32'hFFFF_FF80, rdata, rerr, cyc);
    req(1'b1, 1'b0, 3'b000, 32'h21, 32'h0, rdata, rerr, cyc);
    chk("lb", rdata, 32'hFFFF_FF80);
    req(1'b1, 1'b0, 3'b100, 32'h21, 32'h0, rdata, rerr, cyc);
    chk("lbu", rdata, 32'h0000_0080);
    req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, rdata, rerr, cyc);
    chk("lw_after_sb", rdata, 32'h1122_8044);
    req(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, rdata, rerr, cyc);
    chk("lh_pos", rdata, 32'h0000_1122);
    req(1'b0, 1'b1, 3'b001, 32'h22, 32'h1234_8001, rdata, rerr, cyc);
    req(1'b1, 1'b0, 3'b001, 32'h22, 32'h0, rdata, rerr, cyc);
    chk("lh_neg", rdata, 32'hFFFF_8001);
    req(1'b1, 1'b0, 3'b101, 32'h22, 32'h0, rdata, rerr, cyc);
    chk("lhu", rdata, 32'h0000_8001);
    req(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, rdata, rerr, cyc);
    chk("lw_after_sh", rdata, 32'h8001_8044);

    // Alignment, illegal encodings, conflicting enables
    req(1'b0, 1'b1, 3'b001, 32'h13, 32'h0000_5555, rdata, rerr, cyc);
    chk("sh_mis_err", {31'b0, rerr}, 32'd1);
    req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rdata, rerr, cyc);
    chk("sh_mis_nowr", rdata, 32'hDEAD_BEEF);
    req(1'b1, 1'b0, 3'b010, 32'h22, 32'h0, rdata, rerr, cyc);
    chk("lw_mis_err", {31'b0, rerr}, 32'd1);
    chk("lw_mis_data", rdata, 32'd0);
    req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rdata, rerr, cyc);
    req(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, rdata, rerr, cyc);
    chk("f3_011_err", {31'b0, rerr}, 32'd1);
    chk("f3_011_data", rdata, 32'd0);
    req(1'b0, 1'b1, 3'b100, 32'h10, 32'h0, rdata, rerr, cyc);
    chk("sbu_err", {31'b0, rerr}, 32'd1);
    req(1'b1, 1'b1, 3'b010, 32'h10, 32'h0BAD_0BAD, rdata, rerr, cyc);
    chk("both_err", {31'b0, rerr}, 32'd1);
    req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, rdata, rerr, cyc);
    chk("both_nowr", rdata, 32'hDEAD_BEEF);
    chk("ok_err_clr", {31'b0, rerr}, 32'd0);

    // Requests during WAIT are ignored
    req(1'b0, 1'b1, 3'b010, 32'h54, 32'h0102_0304, rdata, rerr, cyc);
    read_en = 1'b1; Funct3 = 3'b010; Mem_addr_out = 32'h10;
    @(posedge clk); #1;
    read_en = 1'b0; write_en = 1'b1; Mem_addr_out = 32'h54; RS2_data_out = 32'hBAD0_BAD0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) write_en = 1'b0;
      if (done) ndone++;
      @(posedge clk); #1;
    end
    chk("busy_one_done", 32'(ndone), 32'd1);
    chk("busy_ld_data", dmu_out_data, 32'hDEAD_BEEF);
    req(1'b1, 1'b0, 3'b010, 32'h54, 32'h0, rdata, rerr, cyc);
    chk("busy_ignored", rdata, 32'h0102_0304);

    // Reset during WAIT discards the store
    req(1'b0, 1'b1, 3'b010, 32'h40, 32'hCAFE_F00D, rdata, rerr, cyc);
    req(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, rdata, rerr, cyc);
    write_en = 1'b1; Funct3 = 3'b010; Mem_addr_out = 32'h40; RS2_data_out = 32'h1234_5678;
    @(posedge clk); #1;
    write_en = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1; #1;
    chk("mid_rst_data", dmu_out_data, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_done", {31'b0, done}, 32'd0);
    @(posedge clk); #1; rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) ndone++;
      @(posedge clk); #1;
    end
    chk("mid_rst_nodone", 32'(ndone), 32'd0);
    req(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, rdata, rerr, cyc);
    chk("mid_rst_mem", rdata, 32'hCAFE_F00D);

    // Address aliasing modulo 1 KiB
    req(1'b0, 1'b1, 3'b010, 32'h400, 32'hA5A5_5A5A, rdata, rerr, cyc);
    req(1'b1, 1'b0, 3'b010, 32'h000, 32'h0, rdata, rerr, cyc);
    chk("alias", rdata, 32'hA5A5_5A5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
